// File: rtl/vending_pkg.sv
// Shared types and constants for the vending controller.
package vending_pkg;

  // Credit states; encoding 2'b11 is unused and recovers to S0.
  typedef enum logic [1:0] {
    S0  = 2'd0,
    S5  = 2'd1,
    S10 = 2'd2
  } state_t;

  // Coin decode result for one rising edge.
  typedef enum logic [1:0] {
    NONE    = 2'd0,
    C5      = 2'd1,
    C10     = 2'd2,
    INVALID = 2'd3
  } coin_t;

  localparam logic [4:0] PRICE   = 5'd15;
  localparam logic [4:0] COIN_LO = 5'd5;
  localparam logic [4:0] COIN_HI = 5'd10;
  localparam logic [4:0] CHANGE  = 5'd5;

  // Value of a coin in units; no coin and an invalid coin are worth nothing.
  function automatic logic [4:0] coin_value(input coin_t coin);
    case (coin)
      C5:      coin_value = COIN_LO;
      C10:     coin_value = COIN_HI;
      default: coin_value = 5'd0;
    endcase
  endfunction

  // Credit held in a given state.
  function automatic logic [4:0] state_credit(input state_t s);
    case (s)
      S5:      state_credit = COIN_LO;
      S10:     state_credit = COIN_HI;
      default: state_credit = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/vending_coin_decode.sv
// Maps the raw coin-acceptor lines to a coin type for this edge.
module vending_coin_decode
  import vending_pkg::*;
(
  input  logic  c5,
  input  logic  c10,
  output coin_t coin
);

  // Both lines high at once is treated as an invalid coin and ignored downstream.
  always_comb begin
    coin = NONE;
    case ({c5, c10})
      2'b10:   coin = C5;
      2'b01:   coin = C10;
      2'b11:   coin = INVALID;
      default: coin = NONE;
    endcase
  end

endmodule

// File: rtl/vending.sv
// Vending controller: accumulates 5/10-unit coins toward a 15-unit price,
// pulses p_out on a sale and c_out when 5 units of change are due.
module vending
  import vending_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic c5,
  input  logic c10,
  output logic p_out,
  output logic c_out
);

  coin_t      coin;
  state_t     state;
  logic [4:0] total;

  vending_coin_decode u_decode (
    .c5   (c5),
    .c10  (c10),
    .coin (coin)
  );

  // Credit that would be held if this edge's coin were accepted.
  always_comb begin
    total = state_credit(state) + coin_value(coin);
  end

  // State register and one-cycle dispense/change pulses; reset drops any credit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S0;
      p_out <= 1'b0;
      c_out <= 1'b0;
    end else begin
      p_out <= 1'b0;
      c_out <= 1'b0;
      if (state != S0 && state != S5 && state != S10) begin
        state <= S0;
      end else if (coin == C5 || coin == C10) begin
        if (total >= PRICE) begin
          state <= S0;
          p_out <= 1'b1;
          c_out <= ((total - PRICE) == CHANGE);
        end else if (total == COIN_HI) begin
          state <= S10;
        end else begin
          state <= S5;
        end
      end
    end
  end

endmodule

// File: tb/tb_vending.sv
// Directed self-checking bench for the vending controller.
module tb_vending;
  import vending_pkg::*;

  logic clk;
  logic rst;
  logic c5;
  logic c10;
  logic p_out;
  logic c_out;

  int total_checks;
  int passed;

  vending dut (
    .clk   (clk),
    .rst   (rst),
    .c5    (c5),
    .c10   (c10),
    .p_out (p_out),
    .c_out (c_out)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive coin lines, take one rising edge, then settle away from the edge.
  task automatic apply_stimulus(input logic a5, input logic a10);
    c5  = a5;
    c10 = a10;
    @(posedge clk);
    #1;
  endtask

  // Compare state and both outputs against hand-computed values.
  task automatic check_output(input string tag, input state_t exp_st,
                              input logic exp_p, input logic exp_c);
    total_checks++;
    assert (dut.state === exp_st) passed++;
    else $error("[TB] FAIL %s state: got %0d expected %0d", tag, dut.state, exp_st);
    total_checks++;
    assert (p_out === exp_p) passed++;
    else $error("[TB] FAIL %s p_out: got %b expected %b", tag, p_out, exp_p);
    total_checks++;
    assert (c_out === exp_c) passed++;
    else $error("[TB] FAIL %s c_out: got %b expected %b", tag, c_out, exp_c);
  endtask

  initial begin
    total_checks = 0;
    passed       = 0;
    rst = 1'b0;
    c5  = 1'b0;
    c10 = 1'b0;
    @(posedge clk);
    #1;
    check_output("reset_hold", S0, 1'b0, 1'b0);
    rst = 1'b1;

    // 10+10 sets both pulses, then an async reset mid-cycle clears them.
    apply_stimulus(1'b0, 1'b1); check_output("r_10", S10, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1); check_output("r_10_10", S0, 1'b1, 1'b1);
    c10 = 1'b0;
    #2 rst = 1'b0;
    #1 check_output("async_reset", S0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0); check_output("coin_in_reset", S0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    apply_stimulus(1'b0, 1'b0); check_output("idle1", S0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0); check_output("idle2", S0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0); check_output("idle3", S0, 1'b0, 1'b0);

    // 5+5+5 with c5 held for three edges.
    apply_stimulus(1'b1, 1'b0); check_output("555_a", S5, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0); check_output("555_b", S10, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0); check_output("555_c", S0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b0); check_output("555_after", S0, 1'b0, 1'b0);

    // 10+5 then 5+10 back to back.
    apply_stimulus(1'b0, 1'b1); check_output("105_a", S10, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0); check_output("105_b", S0, 1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b0); check_output("510_a", S5, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1); check_output("510_b", S0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b0); check_output("510_after", S0, 1'b0, 1'b0);

    // 10+10 overpay with change.
    apply_stimulus(1'b0, 1'b1); check_output("1010_a", S10, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1); check_output("1010_b", S0, 1'b1, 1'b1);
    apply_stimulus(1'b0, 1'b0); check_output("1010_after", S0, 1'b0, 1'b0);

    // Sale on consecutive edges: 10, 5 | 10, 10.
    apply_stimulus(1'b0, 1'b1); check_output("b2b_a", S10, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0); check_output("b2b_b", S0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b1); check_output("b2b_c", S10, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1); check_output("b2b_d", S0, 1'b1, 1'b1);

    // Reset mid-credit discards the 10 units without change.
    apply_stimulus(1'b0, 1'b1); check_output("midrst_a", S10, 1'b0, 1'b0);
    c10 = 1'b0;
    #2 rst = 1'b0;
    #1 check_output("midrst_clear", S0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    apply_stimulus(1'b1, 1'b0); check_output("midrst_b", S5, 1'b0, 1'b0);

    // Invalid coins are ignored in every state.
    apply_stimulus(1'b1, 1'b1); check_output("inv_s5", S5, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0); check_output("idle_s5", S5, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1); check_output("inv_then10", S0, 1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b1); check_output("inv_s0", S0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1); check_output("inv_s10_pre", S10, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b1); check_output("inv_s10", S10, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0); check_output("inv_s10_post", S0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b0); check_output("final_idle", S0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total_checks);
    $finish;
  end

endmodule
